// File: rtl/ame_line_feeder.sv
// ame_line_feeder: holds a 6x6 pixel window and streams it to the gradient engine as six 6-pixel lines.
// Latency: start sampled at T -> comp_init_o at T+1, line k at T+2+k, feed_done_o one cycle after comp_done_i.
// Backpressure: none toward the loader; writes/starts that cannot be taken are dropped and flag sticky wr_err_o.
// Build option AME_FEED_PINGPONG_EN: two window banks, back-to-back job chaining, up to two jobs outstanding.
module ame_line_feeder #(
  parameter int LINE_DATA_BITS = 7
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_en_i,
  input  logic [2:0]                    wr_row_i,
  input  logic [2:0]                    wr_col_i,
  input  logic [LINE_DATA_BITS-1:0]     wr_data_i,
  input  logic                          start_i,
  input  logic                          dir_i,
  output logic                          busy_o,
  output logic                          wr_err_o,
  output logic                          comp_init_o,
  output logic [6*LINE_DATA_BITS-1:0]   line_data_o,
  input  logic                          comp_done_i,
  output logic                          feed_done_o
);

  localparam int W  = LINE_DATA_BITS;
  localparam int LW = 6 * LINE_DATA_BITS;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_FEED, S_WAIT} state_t;

  state_t          state_q, state_nxt;
  logic [2:0]      k_q, k_nxt;
  logic            chain_q, chain_nxt;
  logic [1:0]      ready_q, ready_nxt, ready_eff;
  logic [1:0]      inuse_q, inuse_nxt, inuse_left;
  logic [1:0]      dir_bank_q;
  logic            wr_bank_q, rd_bank_q, done_bank_q;
  logic            pend_bank_q, pend_dir_q, pend_dir_nxt;
  logic            cur_bank_q, cur_bank_nxt, cur_dir_q, cur_dir_nxt;
  logic            in_range, wr_ok, start_ok, done_ok, drop, launch;
  logic            comp_init_nxt;
  logic [LW-1:0]   line_nxt;
  logic            busy_q, err_q, comp_init_q, feed_done_q;
  logic [LW-1:0]   line_q;
  logic [W-1:0]    pix_q [2][6][6];

  // Decide which loader writes/starts and which engine completions are taken this cycle.
  always_comb begin
    in_range = (wr_row_i < 3'd6) && (wr_col_i < 3'd6);
`ifdef AME_FEED_PINGPONG_EN
    // The write bank may only be touched while it is neither queued nor being fed/awaited.
    wr_ok    = wr_en_i && in_range && !ready_q[wr_bank_q] && !inuse_q[wr_bank_q];
    start_ok = start_i && !ready_q[wr_bank_q] && !inuse_q[wr_bank_q];
    done_ok  = comp_done_i && inuse_q[done_bank_q];
`else
    wr_ok    = wr_en_i && in_range && (state_q == S_IDLE);
    start_ok = start_i && (state_q == S_IDLE);
    done_ok  = comp_done_i && (state_q == S_WAIT);
`endif
    drop      = (wr_en_i && in_range && !wr_ok) || (start_i && !start_ok);
    ready_eff = ready_q;
    if (start_ok) ready_eff[wr_bank_q] = 1'b1;
  end

  // Next-state, job launch and next registered output values.
  always_comb begin
    state_nxt     = state_q;
    k_nxt         = k_q;
    chain_nxt     = chain_q;
    cur_bank_nxt  = cur_bank_q;
    cur_dir_nxt   = cur_dir_q;
    launch        = 1'b0;
    comp_init_nxt = 1'b0;
    inuse_left    = inuse_q;
    if (done_ok) inuse_left[done_bank_q] = 1'b0;

    case (state_q)
      S_IDLE, S_WAIT: begin
        if (ready_eff[rd_bank_q]) begin
          launch        = 1'b1;
          comp_init_nxt = 1'b1;
          state_nxt     = S_INIT;
        end else if (inuse_left != 2'b00) begin
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_INIT: begin
        state_nxt    = S_FEED;
        k_nxt        = 3'd0;
        cur_bank_nxt = pend_bank_q;
        cur_dir_nxt  = pend_dir_q;
      end
      S_FEED: begin
        if (k_q == 3'd5) begin
          if (chain_q) begin
            // Next job's line 0 follows line 5 directly; its comp_init went out with line 5.
            k_nxt        = 3'd0;
            chain_nxt    = 1'b0;
            cur_bank_nxt = pend_bank_q;
            cur_dir_nxt  = pend_dir_q;
          end else if (inuse_left != 2'b00) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          k_nxt = k_q + 3'd1;
          // Launching while moving to line 5 puts comp_init_o alongside line 5.
          if ((k_q == 3'd4) && ready_eff[rd_bank_q]) begin
            launch        = 1'b1;
            comp_init_nxt = 1'b1;
            chain_nxt     = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    ready_nxt = ready_eff;
    inuse_nxt = inuse_left;
    if (launch) begin
      ready_nxt[rd_bank_q] = 1'b0;
      inuse_nxt[rd_bank_q] = 1'b1;
    end
    // A bank started in this very cycle has not stored its direction yet.
    pend_dir_nxt = ready_q[rd_bank_q] ? dir_bank_q[rd_bank_q] : dir_i;

    line_nxt = '0;
    if (state_nxt == S_FEED) begin
      for (int i = 0; i < 6; i++) begin
        line_nxt[i*W +: W] = cur_dir_nxt ? pix_q[cur_bank_nxt][3'(i)][k_nxt]
                                         : pix_q[cur_bank_nxt][k_nxt][3'(i)];
      end
    end
  end

  // State, bank bookkeeping and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      k_q         <= 3'd0;
      chain_q     <= 1'b0;
      ready_q     <= 2'b00;
      inuse_q     <= 2'b00;
      dir_bank_q  <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      done_bank_q <= 1'b0;
      pend_bank_q <= 1'b0;
      pend_dir_q  <= 1'b0;
      cur_bank_q  <= 1'b0;
      cur_dir_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      comp_init_q <= 1'b0;
      feed_done_q <= 1'b0;
      line_q      <= '0;
    end else begin
      state_q     <= state_nxt;
      k_q         <= k_nxt;
      chain_q     <= chain_nxt;
      ready_q     <= ready_nxt;
      inuse_q     <= inuse_nxt;
      cur_bank_q  <= cur_bank_nxt;
      cur_dir_q   <= cur_dir_nxt;
      if (start_ok) dir_bank_q[wr_bank_q] <= dir_i;
      if (launch) begin
        pend_bank_q <= rd_bank_q;
        pend_dir_q  <= pend_dir_nxt;
      end
`ifdef AME_FEED_PINGPONG_EN
      if (start_ok) wr_bank_q   <= ~wr_bank_q;
      if (launch)   rd_bank_q   <= ~rd_bank_q;
      if (done_ok)  done_bank_q <= ~done_bank_q;
`endif
      busy_q      <= (state_nxt != S_IDLE);
      err_q       <= err_q | drop;
      comp_init_q <= comp_init_nxt;
      feed_done_q <= done_ok;
      line_q      <= line_nxt;
    end
  end

  // Window storage; contents are don't-care after reset.
  always_ff @(posedge clk_i) begin
    if (wr_ok) pix_q[wr_bank_q][wr_row_i][wr_col_i] <= wr_data_i;
  end

  assign busy_o      = busy_q;
  assign wr_err_o    = err_q;
  assign comp_init_o = comp_init_q;
  assign line_data_o = line_q;
  assign feed_done_o = feed_done_q;

endmodule

// File: tb/tb_ame_line_feeder.sv
// tb_ame_line_feeder: scoreboard bench for ame_line_feeder.
// Expected per-cycle outputs are queued when stimulus is driven and compared on the falling edge.
// Follows the build's AME_FEED_PINGPONG_EN setting.
module tb_ame_line_feeder;

  localparam int W     = 7;
  localparam int LW    = 6 * W;
  localparam int NEVER = 32'h3fffffff;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          wr_en_i;
  logic [2:0]    wr_row_i, wr_col_i;
  logic [W-1:0]  wr_data_i;
  logic          start_i, dir_i, comp_done_i;
  logic          busy_o, wr_err_o, comp_init_o, feed_done_o;
  logic [LW-1:0] line_data_o;

  ame_line_feeder #(.LINE_DATA_BITS(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .wr_row_i(wr_row_i), .wr_col_i(wr_col_i), .wr_data_i(wr_data_i),
    .start_i(start_i), .dir_i(dir_i),
    .busy_o(busy_o), .wr_err_o(wr_err_o), .comp_init_o(comp_init_o),
    .line_data_o(line_data_o), .comp_done_i(comp_done_i), .feed_done_o(feed_done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [LW-1:0] line;
    logic          ci;
    logic          fd;
    logic          busy;
    logic          err;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           err_from = NEVER;
  int           tb_wb = 0;
  logic [W-1:0] tb_pix [2][6][6];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input int c, input logic [LW-1:0] ln, input logic ci,
                          input logic fd, input logic bz);
    exp_t e;
    e.cyc  = c;
    e.line = ln;
    e.ci   = ci;
    e.fd   = fd;
    e.busy = bz;
    e.err  = (c >= err_from);
    exp_q.push_back(e);
  endtask

  function automatic logic [LW-1:0] line_of(input int bk, input logic d, input int k);
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v[i*W +: W] = d ? tb_pix[bk][i][k] : tb_pix[bk][k][i];
    return v;
  endfunction

  // Compare the DUT against the scheduled expectation for this cycle.
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("line_data", 64'(line_data_o), 64'(e.line));
      check("comp_init", 64'(comp_init_o), 64'(e.ci));
      check("feed_done", 64'(feed_done_o), 64'(e.fd));
      check("busy",      64'(busy_o),      64'(e.busy));
      check("wr_err",    64'(wr_err_o),    64'(e.err));
    end
  end

  task automatic load_window(input int off);
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        wr_en_i   = 1'b1;
        wr_row_i  = 3'(r);
        wr_col_i  = 3'(c);
        wr_data_i = 7'(6 * r + c + off);
        tb_pix[tb_wb][r][c] = 7'(6 * r + c + off);
        step();
      end
    end
    // Out-of-range row: must be ignored without raising an error.
    wr_row_i  = 3'd6;
    wr_col_i  = 3'd0;
    wr_data_i = 7'd127;
    step();
    wr_en_i = 1'b0;
  endtask

  // One job with engine completion at T+8; mode 1 adds a dropped write at T+3 and a dropped start at T+5.
  task automatic std_job(input logic d, input int mode);
    int b;
    b = cyc;
    if (mode == 1) err_from = b + 4;
    start_i = 1'b1;
    dir_i   = d;
    push_exp(b + 1, '0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) push_exp(b + 2 + k, line_of(tb_wb, d, k), 1'b0, 1'b0, 1'b1);
    push_exp(b + 8,  '0, 1'b0, 1'b0, 1'b1);
    push_exp(b + 9,  '0, 1'b0, 1'b1, 1'b0);
    push_exp(b + 10, '0, 1'b0, 1'b0, 1'b0);
`ifdef AME_FEED_PINGPONG_EN
    tb_wb = 1 - tb_wb;
`endif
    step(); start_i = 1'b0;
    step(); step();
    if (mode == 1) begin
      wr_en_i = 1'b1; wr_row_i = 3'd2; wr_col_i = 3'd3; wr_data_i = 7'd99;
    end
    step(); wr_en_i = 1'b0;
    step();
    if (mode == 1) start_i = 1'b1;
    step(); start_i = 1'b0;
    step(); step();
    comp_done_i = 1'b1;
    step(); comp_done_i = 1'b0;
    step(); step();
  endtask

`ifdef AME_FEED_PINGPONG_EN
  // Second bank readied during job 1, chained with no INIT bubble; a third start is dropped.
  task automatic pingpong_chain();
    int b, w, o;
    logic [LW-1:0] ln;
    logic ci, fd;
    b = cyc;
    w = tb_wb;
    o = 1 - w;
    err_from = b + 7;
    tb_pix[o][0][0] = 7'd100;
    tb_pix[o][1][1] = 7'd101;
    tb_pix[o][5][5] = 7'd102;
    for (int c = 1; c <= 16; c++) begin
      ln = '0; ci = 1'b0; fd = 1'b0;
      if (c == 1 || c == 7) ci = 1'b1;
      if (c >= 2 && c <= 7) ln = line_of(w, 1'b0, c - 2);
      if (c >= 8 && c <= 13) ln = line_of(o, 1'b1, c - 8);
      if (c == 9 || c == 15) fd = 1'b1;
      push_exp(b + c, ln, ci, fd, (c <= 14));
    end
    start_i = 1'b1; dir_i = 1'b0;
    step(); start_i = 1'b0;
    wr_en_i = 1'b1; wr_row_i = 3'd0; wr_col_i = 3'd0; wr_data_i = 7'd100;
    step(); wr_row_i = 3'd1; wr_col_i = 3'd1; wr_data_i = 7'd101;
    step(); wr_row_i = 3'd5; wr_col_i = 3'd5; wr_data_i = 7'd102;
    step(); wr_en_i = 1'b0;
    step(); start_i = 1'b1; dir_i = 1'b1;
    step(); dir_i = 1'b0;
    step(); start_i = 1'b0;
    step(); comp_done_i = 1'b1;
    step(); comp_done_i = 1'b0;
    repeat (5) step();
    comp_done_i = 1'b1;
    step(); comp_done_i = 1'b0;
    step(); step();
  endtask
`endif

  // Reset pulse in the middle of FEED; the late engine completion must be ignored.
  task automatic reset_mid_job();
    int b;
    b = cyc;
    start_i = 1'b1; dir_i = 1'b0;
    push_exp(b + 1, '0, 1'b1, 1'b0, 1'b1);
    push_exp(b + 2, line_of(tb_wb, 1'b0, 0), 1'b0, 1'b0, 1'b1);
    push_exp(b + 3, line_of(tb_wb, 1'b0, 1), 1'b0, 1'b0, 1'b1);
    step(); start_i = 1'b0;
    step(); step();
    step();
    rst_i    = 1'b1;
    err_from = NEVER;
    tb_wb    = 0;
    for (int c = 4; c <= 10; c++) push_exp(b + c, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    step(); step(); step();
    step(); comp_done_i = 1'b1;
    step(); comp_done_i = 1'b0;
    step(); step();
  endtask

  initial begin
    rst_i = 1'b1; wr_en_i = 1'b0; wr_row_i = '0; wr_col_i = '0; wr_data_i = '0;
    start_i = 1'b0; dir_i = 1'b0; comp_done_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy",      64'(busy_o),      64'd0);
    check("rst_wr_err",    64'(wr_err_o),    64'd0);
    check("rst_comp_init", 64'(comp_init_o), 64'd0);
    check("rst_line_data", 64'(line_data_o), 64'd0);
    check("rst_feed_done", 64'(feed_done_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();

    load_window(0);
    std_job(1'b0, 0);
    load_window(0);
    std_job(1'b1, 0);

    // Stray engine completion with nothing outstanding.
    comp_done_i = 1'b1;
    push_exp(cyc + 1, '0, 1'b0, 1'b0, 1'b0);
    push_exp(cyc + 2, '0, 1'b0, 1'b0, 1'b0);
    step(); comp_done_i = 1'b0;
    step(); step();

`ifdef AME_FEED_PINGPONG_EN
    pingpong_chain();
`else
    std_job(1'b0, 1);
    std_job(1'b0, 0);
`endif

    load_window(7);
    reset_mid_job();
    load_window(3);
    std_job(1'b0, 0);
    repeat (3) step();

    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
